dot_mem_sequencer: RTL and testbench

Parametrised successor to the dot-product memory controller. Sequences the input and output SRAM banks through three modes: load from file, compute, and write back to file. Each mode is driven by an explicit FSM with runtime vector length, Para_Deg parallel lanes per bank, stall handshakes, and a delay line that aligns result writes with the compute pipeline. Sits between the top-level testbench/file loader and the SRAM array plus dot-product datapath.

---
 rtl/dot_mem_pkg.sv | 22 ++
 rtl/pipe_delay_line.sv | 32 +++
 rtl/dot_mem_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_dot_mem_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/dot_mem_pkg.sv
// rtl/dot_mem_pkg.sv - shared types and helpers for the dot-product memory sequencer
package dot_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMPUTE,
        ST_DRAIN,
        ST_WRITE,
        ST_DONE
    } state_t;

    localparam logic [2:0] MODE_NONE    = 3'b000;
    localparam logic [2:0] MODE_LOAD    = 3'b001;
    localparam logic [2:0] MODE_COMPUTE = 3'b010;
    localparam logic [2:0] MODE_WRITE   = 3'b100;

    function automatic int unsigned ceil_div(input int unsigned len, input int unsigned deg);
        return (len + deg - 1) / deg;
    endfunction

endpackage

// File: rtl/pipe_delay_line.sv
// rtl/pipe_delay_line.sv - fixed-depth shift register with synchronous flush
module pipe_delay_line #(
    parameter int Depth = 5,
    parameter int Width = 8
) (
    input  logic             clk,
    input  logic             flush,
    input  logic [Width-1:0] din,
    output logic [Width-1:0] dout,
    output logic             occupied
);

    logic [Width-1:0] stage_q [Depth];

    always_ff @(posedge clk) begin
        if (flush) begin
            for (int i = 0; i < Depth; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < Depth; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign dout = stage_q[Depth-1];

    // The record's valid flag lives in the MSB.
    always_comb begin
        occupied = 1'b0;
        for (int i = 0; i < Depth; i++) occupied = occupied | stage_q[i][Width-1];
    end

endmodule

// File: rtl/dot_mem_sequencer.sv
// rtl/dot_mem_sequencer.sv - load/compute/write-back sequencer for the dot-product SRAM banks
module dot_mem_sequencer
    import dot_mem_pkg::*;
#(
    parameter int Addr_Width           = 4,
    parameter int Ram_Depth            = 1 << Addr_Width,
    parameter int Nums_SRAM_In         = 2,
    parameter int Nums_SRAM_Out        = 1,
    parameter int Nums_SRAM            = Nums_SRAM_In + Nums_SRAM_Out,
    parameter int Para_Deg             = 2,
    parameter int Nums_Pipeline_Stages = 4,
    parameter int Read_Latency         = 1
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      start_load,
    input  logic                                      start_compute,
    input  logic                                      start_write,
    input  logic                                      abort,
    input  logic [Addr_Width:0]                       vec_len,
    input  logic                                      load_valid,
    input  logic                                      out_ready,
    output logic [2:0]                                mode,
    output logic                                      busy,
    output logic                                      done,
    output logic [Nums_SRAM-1:0]                      Mem_Clear,
    output logic [Nums_SRAM*Para_Deg-1:0]             En_Chip_Select,
    output logic [Nums_SRAM*Para_Deg-1:0]             En_Read,
    output logic [Nums_SRAM*Para_Deg-1:0]             En_Write,
    output logic [Nums_SRAM*Para_Deg*Addr_Width-1:0]  Addr_Read,
    output logic [Nums_SRAM*Para_Deg*Addr_Width-1:0]  Addr_Write,
    output logic [Para_Deg-1:0]                       lane_mask
);

    localparam int CW  = Addr_Width + 1;
    localparam int NL  = Nums_SRAM * Para_Deg;
    localparam int DLY = Read_Latency + Nums_Pipeline_Stages;
    localparam int RW  = 1 + CW + Para_Deg;

    state_t          state_q, state_d;
    logic [CW-1:0]   len_q, len_d, grp_q, grp_d, groups_q, groups_d;
    logic [2:0]      cmd_mode_q, mode_d;
    logic            clr_pending_q;

    logic [CW-1:0]   acc_len, acc_groups, sel_len, sel_groups, sel_grp, sel_base;
    logic [Para_Deg-1:0]   sel_mask;
    logic [Addr_Width-1:0] sel_addr [Para_Deg];
    logic            idle, is_last, abort_now;
    logic            do_wr_in, do_rd_in, do_rd_out;

    logic [NL-1:0]            cs_d, rd_d, wr_d;
    logic [NL*Addr_Width-1:0] ar_d, aw_d;
    logic [Para_Deg-1:0]      mask_d;

    logic [RW-1:0]   rec_in, rec_out;
    logic            dl_occupied, tail_valid;
    logic [CW-1:0]   tail_base;
    logic [Para_Deg-1:0] tail_mask;

    assign abort_now  = abort && (state_q != ST_IDLE);
    assign tail_valid = rec_out[RW-1];
    assign tail_base  = rec_out[RW-2 -: CW];
    assign tail_mask  = rec_out[Para_Deg-1:0];

    pipe_delay_line #(.Depth(DLY), .Width(RW)) u_delay (
        .clk      (clk),
        .flush    (reset || abort_now),
        .din      (rec_in),
        .dout     (rec_out),
        .occupied (dl_occupied)
    );

    // In IDLE the first group is formed from the incoming command; in WRITE a
    // completed handshake presents the following group straight away.
    always_comb begin
        idle       = (state_q == ST_IDLE);
        acc_len    = (vec_len > CW'(Ram_Depth)) ? CW'(Ram_Depth) : vec_len;
        acc_groups = CW'(ceil_div(32'(acc_len), 32'(Para_Deg)));
        sel_len    = idle ? acc_len : len_q;
        sel_groups = idle ? acc_groups : groups_q;
        if (idle)
            sel_grp = '0;
        else if (state_q == ST_WRITE && out_ready)
            sel_grp = grp_q + CW'(1);
        else
            sel_grp = grp_q;
        sel_base = CW'(sel_grp * CW'(Para_Deg));
        is_last  = ((idle ? CW'(1) : grp_q + CW'(1)) >= sel_groups);
        for (int l = 0; l < Para_Deg; l++) begin
            sel_mask[l] = (sel_base + CW'(l)) < sel_len;
            sel_addr[l] = sel_mask[l] ? Addr_Width'(sel_base + CW'(l)) : '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        grp_d     = grp_q;
        groups_d  = groups_q;
        mode_d    = cmd_mode_q;
        do_wr_in  = 1'b0;
        do_rd_in  = 1'b0;
        do_rd_out = 1'b0;

        case (state_q)
            ST_IDLE: begin
                len_d    = acc_len;
                groups_d = acc_groups;
                grp_d    = '0;
                if (start_load) begin
                    mode_d  = MODE_LOAD;
                    state_d = (acc_len == '0) ? ST_DONE : ST_LOAD;
                end else if (start_compute) begin
                    mode_d = MODE_COMPUTE;
                    if (acc_len == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        do_rd_in = 1'b1;
                        grp_d    = CW'(1);
                        state_d  = is_last ? ST_DRAIN : ST_COMPUTE;
                    end
                end else if (start_write) begin
                    mode_d = MODE_WRITE;
                    if (acc_len == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        do_rd_out = 1'b1;
                        state_d   = ST_WRITE;
                    end
                end
            end
            ST_LOAD: begin
                if (load_valid) begin
                    do_wr_in = 1'b1;
                    grp_d    = grp_q + CW'(1);
                    if (is_last) state_d = ST_DONE;
                end
            end
            ST_COMPUTE: begin
                do_rd_in = 1'b1;
                grp_d    = grp_q + CW'(1);
                if (is_last) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!dl_occupied) state_d = ST_DONE;
            end
            ST_WRITE: begin
                if (out_ready && is_last) begin
                    state_d = ST_DONE;
                end else begin
                    do_rd_out = 1'b1;
                    grp_d     = sel_grp;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        cs_d   = '0;
        rd_d   = '0;
        wr_d   = '0;
        ar_d   = '0;
        aw_d   = '0;
        mask_d = do_rd_in ? sel_mask : '0;
        rec_in = do_rd_in ? {1'b1, sel_base, sel_mask} : '0;

        for (int b = 0; b < Nums_SRAM; b++) begin
            for (int l = 0; l < Para_Deg; l++) begin
                if (b < Nums_SRAM_In) begin
                    if (do_wr_in && sel_mask[l]) begin
                        wr_d[b*Para_Deg+l] = 1'b1;
                        aw_d[(b*Para_Deg+l)*Addr_Width +: Addr_Width] = sel_addr[l];
                    end
                    if (do_rd_in && sel_mask[l]) begin
                        rd_d[b*Para_Deg+l] = 1'b1;
                        ar_d[(b*Para_Deg+l)*Addr_Width +: Addr_Width] = sel_addr[l];
                    end
                end else begin
                    if (do_rd_out && sel_mask[l]) begin
                        rd_d[b*Para_Deg+l] = 1'b1;
                        ar_d[(b*Para_Deg+l)*Addr_Width +: Addr_Width] = sel_addr[l];
                    end
                    // Write-back of a compute result leaving the delay line.
                    if (tail_valid && tail_mask[l]) begin
                        wr_d[b*Para_Deg+l] = 1'b1;
                        aw_d[(b*Para_Deg+l)*Addr_Width +: Addr_Width] =
                            Addr_Width'(tail_base + CW'(l));
                    end
                end
            end
        end
        cs_d = rd_d | wr_d;

        if (abort_now) begin
            state_d = ST_IDLE;
            cs_d    = '0;
            rd_d    = '0;
            wr_d    = '0;
            ar_d    = '0;
            aw_d    = '0;
            mask_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            len_q          <= '0;
            grp_q          <= '0;
            groups_q       <= '0;
            cmd_mode_q     <= MODE_NONE;
            clr_pending_q  <= 1'b1;
            mode           <= MODE_NONE;
            busy           <= 1'b0;
            done           <= 1'b0;
            Mem_Clear      <= '0;
            En_Chip_Select <= '0;
            En_Read        <= '0;
            En_Write       <= '0;
            Addr_Read      <= '0;
            Addr_Write     <= '0;
            lane_mask      <= '0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            grp_q          <= grp_d;
            groups_q       <= groups_d;
            cmd_mode_q     <= mode_d;
            clr_pending_q  <= 1'b0;
            Mem_Clear      <= {Nums_SRAM{clr_pending_q}};
            mode           <= (state_d == ST_IDLE) ? MODE_NONE : mode_d;
            busy           <= (state_d != ST_IDLE);
            done           <= (state_d == ST_DONE);
            En_Chip_Select <= cs_d;
            En_Read        <= rd_d;
            En_Write       <= wr_d;
            Addr_Read      <= ar_d;
            Addr_Write     <= aw_d;
            lane_mask      <= mask_d;
        end
    end

endmodule

// File: tb/tb_dot_mem_sequencer.sv
// tb/tb_dot_mem_sequencer.sv - directed self-checking bench for dot_mem_sequencer
module tb_dot_mem_sequencer;

    logic        clk = 1'b0;
    logic        reset, start_load, start_compute, start_write, abort;
    logic [4:0]  vec_len;
    logic        load_valid, out_ready;
    logic [2:0]  mode;
    logic        busy, done;
    logic [2:0]  Mem_Clear;
    logic [5:0]  En_Chip_Select, En_Read, En_Write;
    logic [23:0] Addr_Read, Addr_Write;
    logic [1:0]  lane_mask;

    int checks   = 0;
    int failures = 0;

    logic [5:0]  exp_rd, exp_wr;
    logic [23:0] exp_ar, exp_aw;

    dot_mem_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .start_load     (start_load),
        .start_compute  (start_compute),
        .start_write    (start_write),
        .abort          (abort),
        .vec_len        (vec_len),
        .load_valid     (load_valid),
        .out_ready      (out_ready),
        .mode           (mode),
        .busy           (busy),
        .done           (done),
        .Mem_Clear      (Mem_Clear),
        .En_Chip_Select (En_Chip_Select),
        .En_Read        (En_Read),
        .En_Write       (En_Write),
        .Addr_Read      (Addr_Read),
        .Addr_Write     (Addr_Write),
        .lane_mask      (lane_mask)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Two-lane address image of one bank at a given base, masked lanes read as 0.
    function automatic logic [23:0] bank_addr(input int bank, input int base, input int len);
        logic [23:0] v;
        v = '0;
        for (int l = 0; l < 2; l++)
            if (base + l < len) v[(bank*2+l)*4 +: 4] = 4'(base + l);
        return v;
    endfunction

    initial begin
        reset = 1'b1; start_load = 1'b0; start_compute = 1'b0; start_write = 1'b0;
        abort = 1'b0; vec_len = '0; load_valid = 1'b0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_clear", 32'(Mem_Clear), 32'd0);
        chk("rst_en", 32'(En_Chip_Select | En_Read | En_Write), 32'd0);
        chk("rst_mode", 32'(mode), 32'd0);

        reset = 1'b0; tick();
        chk("clr_pulse", 32'(Mem_Clear), 32'h7);
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_en", 32'(En_Chip_Select | En_Read | En_Write), 32'd0);
        tick();
        chk("clr_once", 32'(Mem_Clear), 32'd0);

        // LOAD, len 5, load_valid 1,0,1,1
        start_load = 1'b1; vec_len = 5'd5; tick(); start_load = 1'b0;
        chk("ld_mode", 32'(mode), 32'h1);
        chk("ld_busy", 32'(busy), 32'd1);
        chk("ld_wait_en", 32'(En_Write), 32'd0);
        load_valid = 1'b1; tick();
        chk("ld0_en", 32'(En_Write), 32'h0F);
        chk("ld0_cs", 32'(En_Chip_Select), 32'h0F);
        chk("ld0_addr", 32'(Addr_Write), 32'h001010);
        chk("ld0_done", 32'(done), 32'd0);
        load_valid = 1'b0; tick();
        chk("ld_stall_en", 32'(En_Chip_Select | En_Write), 32'd0);
        chk("ld_stall_addr", 32'(Addr_Write), 32'd0);
        load_valid = 1'b1; tick();
        chk("ld1_en", 32'(En_Write), 32'h0F);
        chk("ld1_addr", 32'(Addr_Write), 32'h003232);
        tick();
        chk("ld2_en", 32'(En_Write), 32'h05);
        chk("ld2_addr", 32'(Addr_Write), 32'h000404);
        chk("ld2_done", 32'(done), 32'd1);
        chk("ld2_rd", 32'(En_Read), 32'd0);
        load_valid = 1'b0; tick();
        chk("ld_end_done", 32'(done), 32'd0);
        chk("ld_end_busy", 32'(busy), 32'd0);
        chk("ld_end_mode", 32'(mode), 32'd0);

        // COMPUTE, len 16: reads cycles 0..7, writes 5..12, done 13
        start_compute = 1'b1; vec_len = 5'd16; tick(); start_compute = 1'b0;
        for (int c = 0; c < 15; c++) begin
            exp_rd = (c < 8) ? 6'h0F : 6'h00;
            exp_ar = (c < 8) ? (bank_addr(0, 2*c, 16) | bank_addr(1, 2*c, 16)) : 24'h0;
            exp_wr = (c >= 5 && c <= 12) ? 6'h30 : 6'h00;
            exp_aw = (c >= 5 && c <= 12) ? bank_addr(2, 2*(c-5), 16) : 24'h0;
            chk($sformatf("cmp_rd_c%0d", c), 32'(En_Read), 32'(exp_rd));
            chk($sformatf("cmp_ar_c%0d", c), 32'(Addr_Read), 32'(exp_ar));
            chk($sformatf("cmp_wr_c%0d", c), 32'(En_Write), 32'(exp_wr));
            chk($sformatf("cmp_aw_c%0d", c), 32'(Addr_Write), 32'(exp_aw));
            chk($sformatf("cmp_mask_c%0d", c), 32'(lane_mask), (c < 8) ? 32'h3 : 32'h0);
            chk($sformatf("cmp_done_c%0d", c), 32'(done), (c == 13) ? 32'd1 : 32'd0);
            chk($sformatf("cmp_mode_c%0d", c), 32'(mode), (c <= 13) ? 32'h2 : 32'h0);
            tick();
        end

        // LOAD with oversize length saturates to 16 -> 8 groups
        start_load = 1'b1; vec_len = 5'd31; tick(); start_load = 1'b0;
        load_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("sat_done_%0d", i), 32'(done), (i == 8) ? 32'd1 : 32'd0);
        end
        chk("sat_last_en", 32'(En_Write), 32'h0F);
        chk("sat_last_addr", 32'(Addr_Write), 32'h00FEFE);
        load_valid = 1'b0; tick();
        chk("sat_idle", 32'(busy), 32'd0);

        // WRITE, len 4, out_ready low for three cycles
        start_write = 1'b1; vec_len = 5'd4; out_ready = 1'b0; tick(); start_write = 1'b0;
        chk("wr_mode", 32'(mode), 32'h4);
        chk("wr_h0_en", 32'(En_Read), 32'h30);
        chk("wr_h0_addr", 32'(Addr_Read), 32'h100000);
        chk("wr_h0_inbank", 32'(En_Write), 32'd0);
        tick();
        chk("wr_h1_addr", 32'(Addr_Read), 32'h100000);
        tick();
        chk("wr_h2_en", 32'(En_Read), 32'h30);
        chk("wr_h2_addr", 32'(Addr_Read), 32'h100000);
        out_ready = 1'b1; tick();
        chk("wr_g1_en", 32'(En_Read), 32'h30);
        chk("wr_g1_addr", 32'(Addr_Read), 32'h320000);
        chk("wr_g1_done", 32'(done), 32'd0);
        tick();
        chk("wr_done", 32'(done), 32'd1);
        chk("wr_done_en", 32'(En_Read), 32'd0);
        out_ready = 1'b0; tick();
        chk("wr_idle", 32'(busy), 32'd0);

        // abort during COMPUTE
        start_compute = 1'b1; vec_len = 5'd16; tick(); start_compute = 1'b0;
        tick(); tick();
        chk("ab_pre_addr", 32'(Addr_Read), 32'h005454);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("ab_en", 32'(En_Chip_Select | En_Read | En_Write), 32'd0);
        chk("ab_addr", 32'(Addr_Read | Addr_Write), 32'd0);
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_done", 32'(done), 32'd0);
        chk("ab_mask", 32'(lane_mask), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("ab_late_wr_%0d", i), 32'(En_Write), 32'd0);
            chk($sformatf("ab_late_done_%0d", i), 32'(done), 32'd0);
        end

        // simultaneous load+compute with zero length
        start_load = 1'b1; start_compute = 1'b1; vec_len = 5'd0; tick();
        start_load = 1'b0; start_compute = 1'b0;
        chk("z_done", 32'(done), 32'd1);
        chk("z_mode", 32'(mode), 32'h1);
        chk("z_en", 32'(En_Chip_Select), 32'd0);
        tick();
        chk("z_done_off", 32'(done), 32'd0);
        chk("z_busy_off", 32'(busy), 32'd0);
        tick();
        chk("z_dropped", 32'(busy), 32'd0);

        // reset during WRITE: no done, clear strobe afterwards
        start_write = 1'b1; vec_len = 5'd2; tick(); start_write = 1'b0;
        chk("mr_en", 32'(En_Read), 32'h30);
        reset = 1'b1; tick();
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_done", 32'(done), 32'd0);
        chk("mr_en_off", 32'(En_Read), 32'd0);
        reset = 1'b0; tick();
        chk("mr_clear", 32'(Mem_Clear), 32'h7);
        chk("mr_no_done", 32'(done), 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
